lift_req_queue: RTL and testbench

Request queue directly upstream of the lift controller FSM. Captures floor/direction call requests from the button-decode logic and holds them in arrival order. Presents the oldest pending request on `din` with a `qEmpty` flag, and retires it when the controller pulses `done`. Optionally suppresses duplicate calls so a button pressed repeatedly occupies at most one slot.

---
 rtl/lift_req_queue.sv | 90 +++++++++
 tb/tb_lift_req_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lift_req_queue.sv
// In-order request queue between the button-decode logic and the lift controller FSM.
// Define LIFT_REQ_DEDUP_EN to drop repeat calls for a code that is already queued.
module lift_req_queue #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_vld,
  input  logic [2:0]    req_code,
  input  logic          done,
  output logic [2:0]    din,
  output logic          qEmpty,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          legal;
  logic          dup;
  logic          pop;
  logic          push;
  logic          ovf_set;

  assign qEmpty = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign din    = qEmpty ? 3'b000 : mem[rd_ptr];

  // NOTE: every always_comb output gets a default before the case, otherwise a latch is inferred.
  always_comb begin
    legal = 1'b0;
    case (req_code)
      3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100: legal = 1'b1;
      default:                                          legal = 1'b0;
    endcase
  end

  assign pop = done & ~qEmpty;

`ifdef LIFT_REQ_DEDUP_EN
  logic [7:0] pending;
  logic [7:0] pending_nxt;

  // A code being retired this cycle may be re-requested in the same cycle.
  assign dup = pending[req_code] & ~(pop & (din == req_code));

  // NOTE: combinational blocks use blocking '=', clocked blocks use non-blocking '<='.
  always_comb begin
    pending_nxt = pending;
    if (pop)  pending_nxt[din]      = 1'b0;
    if (push) pending_nxt[req_code] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end
`else
  assign dup = 1'b0;
`endif

  assign push    = req_vld & legal & ~dup & (~full | pop);
  assign ovf_set = req_vld & legal & ~dup & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push & ~pop)      count <= count + 1'b1;
      else if (pop & ~push) count <= count - 1'b1;
      if (ovf_set) overflow <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; count gates din, so stale slots are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_code;
  end

endmodule

// File: tb/tb_lift_req_queue.sv
// Scoreboard bench for lift_req_queue: a queue-based reference model predicts each retired
// head; a negedge monitor compares it whenever the DUT pops. Honours LIFT_REQ_DEDUP_EN.
module tb_lift_req_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          req_vld;
  logic [2:0]    req_code;
  logic          done;
  logic [2:0]    din;
  logic          qEmpty;
  logic [CW-1:0] count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [2:0] model_q[$];
  logic       model_ovf;
  logic [2:0] exp_q[$];

  lift_req_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_code (req_code),
    .done     (done),
    .din      (din),
    .qEmpty   (qEmpty),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [2:0] c);
    return c inside {3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100};
  endfunction

  function automatic bit model_holds(input logic [2:0] c);
    foreach (model_q[i]) if (model_q[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_state();
    logic [2:0] head;
    head = (model_q.size() != 0) ? model_q[0] : 3'b000;
    check("count",    32'(count),    32'(model_q.size()));
    check("qEmpty",   32'(qEmpty),   32'(model_q.size() == 0));
    check("din",      32'(din),      32'(head));
    check("overflow", 32'(overflow), 32'(model_ovf));
  endtask

  // One clock of stimulus; the model is advanced by the queue rules and the expected
  // retired head (if any) goes to the scoreboard for the monitor.
  task automatic cycle(input bit vld, input logic [2:0] code, input bit d);
    bit         pop;
    bit         dup;
    bit         full;
    logic [2:0] head;
    req_vld  = vld;
    req_code = code;
    done     = d;
    pop  = d && (model_q.size() != 0);
    head = pop ? model_q[0] : 3'b000;
    full = (model_q.size() == DEPTH);
    dup  = 1'b0;
`ifdef LIFT_REQ_DEDUP_EN
    dup = model_holds(code) && !(pop && head == code);
`endif
    if (pop) exp_q.push_back(model_q.pop_front());
    if (vld && is_legal(code) && !dup) begin
      if (!full || pop) model_q.push_back(code);
      else              model_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    done    = 1'b0;
    check_state();
  endtask

  task automatic do_reset(input bit vld, input logic [2:0] code, input bit d);
    rst      = 1'b1;
    req_vld  = vld;
    req_code = code;
    done     = d;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    req_vld = 1'b0;
    done    = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    check_state();
  endtask

  // Monitor: a DUT pop happens when done is high and the queue is not empty.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (!qEmpty) begin
        if (exp_q.size() == 0) check("pop_unexpected", 32'(qEmpty), 32'd1);
        else                   check("pop_head", 32'(din), 32'(exp_q.pop_front()));
      end else if (exp_q.size() != 0) begin
        check("pop_missing", 32'(qEmpty), 32'd0);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst      = 1'b1;
    req_vld  = 1'b0;
    req_code = 3'b000;
    done     = 1'b0;
    model_ovf = 1'b0;

    do_reset(1'b0, 3'b000, 1'b0);
    repeat (5) cycle(1'b0, 3'b000, 1'b0);
    check("idle_empty", 32'(qEmpty), 32'd1);
    check("idle_din",   32'(din),    32'd0);
    cycle(1'b0, 3'b000, 1'b1);
    check("done_when_empty_count", 32'(count), 32'd0);

    // In-order retirement with idle gaps between pops.
    cycle(1'b1, 3'b011, 1'b0);
    cycle(1'b1, 3'b110, 1'b0);
    cycle(1'b1, 3'b100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 3'b000, 1'b1);
      cycle(1'b0, 3'b000, 1'b0);
    end
    check("empty_after_three_pops", 32'(qEmpty), 32'd1);

    // Overflow on a full queue, then a pop exposes the second entry.
    cycle(1'b1, 3'b001, 1'b0);
    cycle(1'b1, 3'b010, 1'b0);
    cycle(1'b1, 3'b011, 1'b0);
    cycle(1'b1, 3'b111, 1'b0);
    cycle(1'b1, 3'b100, 1'b0);
    check("full_count",   32'(count),    32'(DEPTH));
    check("overflow_set", 32'(overflow), 32'd1);
    cycle(1'b0, 3'b000, 1'b1);
    check("head_after_overflow_pop", 32'(din), 32'b010);

    // Full with simultaneous pop and push: push takes the freed slot.
    do_reset(1'b0, 3'b000, 1'b0);
    cycle(1'b1, 3'b001, 1'b0);
    cycle(1'b1, 3'b010, 1'b0);
    cycle(1'b1, 3'b011, 1'b0);
    cycle(1'b1, 3'b111, 1'b0);
    cycle(1'b1, 3'b100, 1'b1);
    check("full_pop_push_count", 32'(count),    32'(DEPTH));
    check("full_pop_push_ovf",   32'(overflow), 32'd0);
    repeat (3) cycle(1'b0, 3'b000, 1'b1);
    check("tail_is_new_push", 32'(din), 32'b100);

    // Repeat calls.
    do_reset(1'b0, 3'b000, 1'b0);
    cycle(1'b1, 3'b010, 1'b0);
    cycle(1'b1, 3'b010, 1'b0);
`ifdef LIFT_REQ_DEDUP_EN
    check("repeat_count", 32'(count), 32'd1);
`else
    check("repeat_count", 32'(count), 32'd2);
`endif
    cycle(1'b1, 3'b010, 1'b1);
    check("pop_push_same_code_din", 32'(din), 32'b010);

    // Illegal codes are discarded; reset flushes a freshly pushed entry.
    do_reset(1'b0, 3'b000, 1'b0);
    cycle(1'b1, 3'b000, 1'b0);
    cycle(1'b1, 3'b101, 1'b0);
    check("illegal_not_queued", 32'(count), 32'd0);
    cycle(1'b1, 3'b001, 1'b0);
    do_reset(1'b1, 3'b011, 1'b1);
    check("reset_flush_count",  32'(count),  32'd0);
    check("reset_flush_empty",  32'(qEmpty), 32'd1);

    // Randomized traffic with occasional mid-operation resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0)
        do_reset(1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom_range(0, 1)));
      else
        cycle(1'($urandom_range(0, 1)), 3'($urandom), $urandom_range(0, 2) == 0);
    end

    repeat (DEPTH + 1) cycle(1'b0, 3'b000, 1'b1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
